demux_1_4: RTL and testbench



---
 rtl/demux_1_4.sv | 37 +++
 tb/tb_demux_1_4.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/demux_1_4.sv
// 1-to-4 demultiplexer: steers I onto lane S of Y, all other lanes zero, registered output.
// Define DEMUX_1_4_COMB_BYPASS_EN to remove the output register (Y combinational, clk unused).
module demux_1_4 #(
    parameter int DATA_W = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     I,
    input  logic [1:0]            S,
    output logic [4*DATA_W-1:0]   Y
);

    logic [4*DATA_W-1:0] y_next;

    // Per-lane compare so an unknown S propagates X rather than silently selecting a lane.
    always_comb begin
        y_next = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            y_next[k*DATA_W +: DATA_W] = (S == 2'(k)) ? I : '0;
        end
    end

`ifdef DEMUX_1_4_COMB_BYPASS_EN
    always_comb begin
        Y = rst ? '0 : y_next;
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y <= '0;
        end else begin
            Y <= y_next;
        end
    end
`endif

endmodule

// File: tb/tb_demux_1_4.sv
// Self-checking bench for demux_1_4: directed cases plus randomized steps against a shift-based model.
module tb_demux_1_4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i1;
    logic [1:0]  s1;
    logic [3:0]  y1;
    logic [7:0]  i8;
    logic [1:0]  s8;
    logic [31:0] y8;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    demux_1_4 #(.DATA_W(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .I   (i1),
        .S   (s1),
        .Y   (y1)
    );

    demux_1_4 #(.DATA_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .I   (i8),
        .S   (s8),
        .Y   (y8)
    );

    // Reference: the data word shifted up by S lane-widths inside a zero word.
    function automatic logic [3:0] model1(input logic i, input logic [1:0] s);
        return 4'(i) << s;
    endfunction

    function automatic logic [31:0] model8(input logic [7:0] i, input logic [1:0] s);
        return 32'(i) << (8 * s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ni1, input logic [1:0] ns1,
                         input logic [7:0] ni8, input logic [1:0] ns8);
        @(negedge clk);
        i1 = ni1;
        s1 = ns1;
        i8 = ni8;
        s8 = ns8;
    endtask

    // Inputs applied before the edge; results checked just after it.
    task automatic step_chk(input string tag);
        logic [3:0]  e1;
        logic [31:0] e8;
        e1 = model1(i1, s1);
        e8 = model8(i8, s8);
        @(posedge clk);
        #1;
        chk({tag, "_w1"}, 32'(y1), 32'(e1));
        chk({tag, "_w8"}, y8, e8);
    endtask

    initial begin
        rst = 1'b1;
        i1  = 1'b1;
        s1  = 2'b10;
        i8  = 8'h00;
        s8  = 2'b00;
        #2;
        chk("reset_y1", 32'(y1), 32'h0);
        chk("reset_y8", y8, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        #1;
`ifdef DEMUX_1_4_COMB_BYPASS_EN
        chk("deassert_pre_edge", 32'(y1), 32'h4);
`else
        chk("deassert_pre_edge", 32'(y1), 32'h0);
`endif
        @(posedge clk);
        #1;
        chk("first_edge", 32'(y1), 32'h4);

        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k), 8'h00, 2'(k));
            step_chk($sformatf("walk_s%0d", k));
        end
        chk("walk_last", 32'(y1), 32'h8);

        drive(1'b1, 2'b11, 8'hFF, 2'b00);
        step_chk("i1_s3");
        drive(1'b0, 2'b11, 8'h00, 2'b11);
        step_chk("i0_s3");
        chk("i0_s3_direct", 32'(y1), 32'h0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 2'(k), 8'h00, 2'(k));
            step_chk($sformatf("zero_s%0d", k));
        end

        drive(1'b1, 2'b00, 8'hA5, 2'b01);
        step_chk("a5_s1");
        chk("a5_s1_direct", y8, 32'h0000_A500);
        drive(1'b1, 2'b00, 8'hA5, 2'b11);
        step_chk("a5_s3");
        chk("a5_s3_direct", y8, 32'hA500_0000);

        drive(1'b1, 2'b01, 8'h3C, 2'b10);
        step_chk("pre_async");
        chk("pre_async_y1", 32'(y1), 32'h2);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_clear_y1", 32'(y1), 32'h0);
        chk("async_clear_y8", y8, 32'h0);
        @(posedge clk);
        #1;
        chk("reset_held_y1", 32'(y1), 32'h0);
        chk("reset_held_y8", y8, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step_chk("post_reset");

        for (int n = 0; n < 40; n++) begin
            drive(1'($urandom), 2'($urandom_range(3)), 8'($urandom), 2'($urandom_range(3)));
            step_chk($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
